// File: rtl/pr_hrav_axil_pkg.sv
// Shared AXI4-Lite response codes and master FSM encodings for the HR-AV initiator blocks.
package pr_hrav_axil_pkg;

  localparam logic [1:0] AXI_RESP_OK     = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int TIMER_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RESPOND = 3'd5
  } master_state_t;

  // States in which the per-transaction wait timer runs.
  function automatic logic is_bus_phase(input master_state_t s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) || (s == ST_RD_REQ) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/pr_hrav_timeout_cnt.sv
// Saturating wait-cycle counter; expired flags the last permitted cycle (limit-1). limit=0 disables it.
module pr_hrav_timeout_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign expired = (limit != '0) && (count_reg == (limit - WIDTH'(1)));

endmodule

// File: rtl/pr_hrav_axil_master.sv
// Single-beat AXI4-Lite master: one cmd in, one AXI read/write, one rsp out, with a wait timeout
// that abandons a transaction stuck on a slave region under partial reconfiguration.
module pr_hrav_axil_master
  import pr_hrav_axil_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

  master_state_t state_reg;
  logic          aw_done_reg, w_done_reg;
  logic          aw_hs, w_hs, aw_done_next, w_done_next;
  logic          timer_active, timed_out, phase_done, abort;

  assign cmd_ready    = (state_reg == ST_IDLE);
  assign timer_active = is_bus_phase(state_reg);
  assign aw_hs        = M_AWVALID && M_AWREADY;
  assign w_hs         = M_WVALID && M_WREADY;
  assign aw_done_next = aw_done_reg || aw_hs;
  assign w_done_next  = w_done_reg || w_hs;

  // The handshake that lets the current state move on; it beats a coincident timeout.
  always_comb begin
    phase_done = 1'b0;
    unique case (state_reg)
      ST_WR_REQ:  phase_done = aw_done_next && w_done_next;
      ST_WR_RESP: phase_done = M_BVALID && M_BREADY;
      ST_RD_REQ:  phase_done = M_ARVALID && M_ARREADY;
      ST_RD_DATA: phase_done = M_RVALID && M_RREADY;
      default:    phase_done = 1'b0;
    endcase
  end

  assign abort = timer_active && timed_out && !phase_done;

  pr_hrav_timeout_cnt #(
    .WIDTH (TIMER_WIDTH)
  ) u_timeout_cnt (
    .clk     (ACLK),
    .srst    (ARESET),
    .clear   (cmd_valid && cmd_ready),
    .enable  (timer_active),
    .limit   (TIMEOUT_LIMIT),
    .expired (timed_out)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg   <= ST_IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      M_AWADDR    <= '0;
      M_AWVALID   <= 1'b0;
      M_WDATA     <= '0;
      M_WSTRB     <= '0;
      M_WVALID    <= 1'b0;
      M_BREADY    <= 1'b0;
      M_ARADDR    <= '0;
      M_ARVALID   <= 1'b0;
      M_RREADY    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= AXI_RESP_OK;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_rnw) begin
              M_ARADDR  <= cmd_addr;
              M_ARVALID <= 1'b1;
              state_reg <= ST_RD_REQ;
            end else begin
              M_AWADDR    <= cmd_addr;
              M_WDATA     <= cmd_wdata;
              M_WSTRB     <= cmd_wstrb;
              M_AWVALID   <= 1'b1;
              M_WVALID    <= 1'b1;
              aw_done_reg <= 1'b0;
              w_done_reg  <= 1'b0;
              state_reg   <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          // AW and W complete independently, in either order or together.
          aw_done_reg <= aw_done_next;
          w_done_reg  <= w_done_next;
          if (aw_hs) M_AWVALID <= 1'b0;
          if (w_hs)  M_WVALID  <= 1'b0;
          if (phase_done) begin
            M_BREADY  <= 1'b1;
            state_reg <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (phase_done) begin
            M_BREADY    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= M_BRESP;
            rsp_timeout <= 1'b0;
            state_reg   <= ST_RESPOND;
          end
        end
        ST_RD_REQ: begin
          if (phase_done) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state_reg <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (phase_done) begin
            M_RREADY    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= M_RDATA;
            rsp_resp    <= M_RRESP;
            rsp_timeout <= 1'b0;
            state_reg   <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Timeout recovery drops VALID/READY without a handshake; only safe for a region under PR.
      if (abort) begin
        M_AWVALID   <= 1'b0;
        M_WVALID    <= 1'b0;
        M_BREADY    <= 1'b0;
        M_ARVALID   <= 1'b0;
        M_RREADY    <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_resp    <= AXI_RESP_OK;
        rsp_timeout <= 1'b1;
        state_reg   <= ST_RESPOND;
      end
    end
  end

endmodule
